// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 9-bit CPU sequencer: opcode and FSM state encodings.
package cpu_sequencer_pkg;

    localparam int INSTR_W = 9;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_XOR = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_ADD = 3'b100,
        OP_LW  = 3'b101,
        OP_SW  = 3'b110,
        OP_BR  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } seq_state_t;

    function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] instr);
        return opcode_t'(instr[8:6]);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Memory handshakes: req is held high (and its qualifiers stable) until ready;
// a transfer completes on the rising edge where req && ready are both high.
interface cpu_sequencer_if;
    import cpu_sequencer_pkg::*;

    logic               imem_req;
    logic               imem_ready;
    logic [INSTR_W-1:0] instr;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, instr, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, instr, dmem_ready
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer: owns PC/IR, drives the memory handshakes and emits
// one-cycle phase strobes for the datapath, plus busy-cycle/retire counters.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int PROG_LEN = 256,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    cpu_sequencer_if.master    bus,
    input  logic               br_cond,
    input  logic [PC_W-1:0]    br_target,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               reg_we,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   cyc_cnt,
    output logic [CNT_W-1:0]   ret_cnt,
    output seq_state_t         dbg_state
);

    localparam int WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    seq_state_t        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [PC_W:0]     nextpc;
    logic              retire;
    logic              run_start;
    logic              waiting;
    logic              ready_now;
    logic              timeout_hit;
    opcode_t           op;

    assign op          = get_opcode(ir);
    assign run_start   = (state == IDLE) && start;
    assign waiting     = (state == FETCH) || (state == MEM);
    assign ready_now   = (state == FETCH) ? bus.imem_ready : bus.dmem_ready;
    // timeout_hit marks the TIMEOUT-th consecutive cycle without ready
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TO_LAST));
    assign dbg_state   = state;

    always_comb begin
        state_nxt    = state;
        nextpc       = {1'b0, pc} + 1'b1;
        retire       = 1'b0;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        reg_we       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = FETCH;
            FETCH: begin
                busy         = 1'b1;
                bus.imem_req = 1'b1;
                if (bus.imem_ready) state_nxt = DECODE;
                else if (timeout_hit) state_nxt = ERR;
            end
            DECODE: begin
                busy      = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (op == OP_BR) begin
                    retire = 1'b1;
                    if (br_cond) nextpc = {1'b0, br_target};
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                busy         = 1'b1;
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (op == OP_SW);
                if (bus.dmem_ready) begin
                    if (op == OP_SW) retire = 1'b1;
                    else state_nxt = WB;
                end else if (timeout_hit) begin
                    state_nxt = ERR;
                end
            end
            WB: begin
                busy   = 1'b1;
                reg_we = 1'b1;
                retire = 1'b1;
            end
            HALT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: err = 1'b1;
            default: state_nxt = IDLE;
        endcase
        // nextpc is one bit wider than pc so the end-of-program test never wraps
        if (retire) state_nxt = (nextpc >= (PC_W+1)'(PROG_LEN)) ? HALT : FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (run_start) pc <= '0;
            if ((state == FETCH) && bus.imem_ready) ir <= bus.instr;
            if (retire) pc <= nextpc[PC_W-1:0];
            if ((state_nxt != state) && ((state_nxt == FETCH) || (state_nxt == MEM)))
                wait_cnt <= '0;
            else if (waiting && !ready_now)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (busy),
        .q     (cyc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (retire),
        .q     (ret_cnt)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: two instances (short program / long program
// with narrow counters) driven through a linear sequence of hand-computed checks.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam logic [8:0] I_ADD = 9'h100;
    localparam logic [8:0] I_LW  = 9'h141;
    localparam logic [8:0] I_SW  = 9'h182;
    localparam logic [8:0] I_BR  = 9'h1C0;
    localparam logic [8:0] I_AND = 9'h000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: PROG_LEN=3, TIMEOUT=8 ----------------
    cpu_sequencer_if a_bus();
    logic       a_start = 1'b0, a_br_cond = 1'b0, a_imem_en = 1'b1;
    logic [7:0] a_br_target = 8'h00, a_pc;
    logic [8:0] a_ir;
    logic       a_reg_we, a_busy, a_done, a_err;
    logic [15:0] a_cyc, a_ret;
    seq_state_t a_state;
    logic [8:0] a_prog [0:255];
    int         a_dly = 0;
    int         a_wait;

    assign a_bus.instr      = a_prog[a_pc];
    assign a_bus.imem_ready = a_imem_en;
    assign a_bus.dmem_ready = a_bus.dmem_req && (a_wait == a_dly);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) a_wait <= 0;
        else if (a_bus.dmem_req && !a_bus.dmem_ready) a_wait <= a_wait + 1;
        else a_wait <= 0;
    end

    cpu_sequencer #(.PC_W(8), .PROG_LEN(3), .TIMEOUT(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .bus(a_bus.master),
        .br_cond(a_br_cond), .br_target(a_br_target), .pc(a_pc), .ir(a_ir),
        .reg_we(a_reg_we), .busy(a_busy), .done(a_done), .err(a_err),
        .cyc_cnt(a_cyc), .ret_cnt(a_ret), .dbg_state(a_state)
    );

    // ---------------- instance B: PROG_LEN=200, CNT_W=4 ----------------
    cpu_sequencer_if b_bus();
    logic       b_start = 1'b0, b_br_cond = 1'b0;
    logic [7:0] b_br_target = 8'h00, b_pc;
    logic [8:0] b_ir;
    logic       b_reg_we, b_busy, b_done, b_err;
    logic [3:0] b_cyc, b_ret;
    seq_state_t b_state;
    logic [8:0] b_prog [0:255];

    assign b_bus.instr      = b_prog[b_pc];
    assign b_bus.imem_ready = 1'b1;
    assign b_bus.dmem_ready = 1'b1;

    cpu_sequencer #(.PC_W(8), .PROG_LEN(200), .TIMEOUT(64), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .bus(b_bus.master),
        .br_cond(b_br_cond), .br_target(b_br_target), .pc(b_pc), .ir(b_ir),
        .reg_we(b_reg_we), .busy(b_busy), .done(b_done), .err(b_err),
        .cyc_cnt(b_cyc), .ret_cnt(b_ret), .dbg_state(b_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] we_q[$];
    logic [31:0] done_q[$];
    int rd_n, wr_n, ireq_n, err_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_queue(input string tag, input logic [31:0] got[$]);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({tag, "_cyc"}, got[i], exp_q[i]);
    endtask

    // ---------------- drivers ----------------
    task automatic start_a();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic start_b();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    // Called at the negedge of cycle 1 (first cycle after the start edge).
    task automatic run_a(input int ncyc, input int restart_at);
        we_q.delete(); done_q.delete();
        rd_n = 0; wr_n = 0; ireq_n = 0; err_at = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (a_reg_we) we_q.push_back(c);
            if (a_done) done_q.push_back(c);
            if (a_bus.dmem_req && !a_bus.dmem_we) rd_n++;
            if (a_bus.dmem_req && a_bus.dmem_we) wr_n++;
            if (a_bus.imem_req) ireq_n++;
            if (a_err && err_at == 0) err_at = c;
            a_start = (c == restart_at);
            @(negedge clk);
        end
        a_start = 1'b0;
    endtask

    task automatic wait_b(input seq_state_t st, input logic [7:0] pcv, input int limit,
                          input string tag);
        int found = 0;
        for (int i = 0; i < limit && found == 0; i++) begin
            if (b_state == st && b_pc == pcv) found = 1;
            else @(negedge clk);
        end
        chk(tag, found, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            a_prog[i] = I_AND;
            b_prog[i] = I_AND;
        end

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_state", a_state, IDLE);
        chk("rst_pc", a_pc, 0);
        chk("rst_ir", a_ir, 0);
        chk("rst_outs", {a_bus.imem_req, a_bus.dmem_req, a_reg_we, a_busy, a_done, a_err}, 0);
        chk("rst_cnts", {a_cyc, a_ret}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- ADD,ADD,ADD with ready tied high ----
        a_prog[0] = I_ADD | 9'h05; a_prog[1] = I_ADD | 9'h0A; a_prog[2] = I_ADD | 9'h3F;
        start_a();
        chk("t1_fetch_state", a_state, FETCH);
        chk("t1_imem_req", a_bus.imem_req, 1);
        run_a(14, 0);
        exp_q = '{32'd4, 32'd8, 32'd12};
        chk_queue("t1_reg_we", we_q);
        exp_q = '{32'd13};
        chk_queue("t1_done", done_q);
        chk("t1_ret", a_ret, 3);
        chk("t1_cyc", a_cyc, 12);
        chk("t1_pc", a_pc, 3);
        chk("t1_ir", a_ir, 9'h13F);
        chk("t1_idle", a_state, IDLE);

        // ---- start pulsed while busy has no effect ----
        start_a();
        run_a(14, 6);
        exp_q = '{32'd4, 32'd8, 32'd12};
        chk_queue("t6_reg_we", we_q);
        exp_q = '{32'd13};
        chk_queue("t6_done", done_q);
        chk("t6_ret", a_ret, 3);

        // ---- LW, SW with dmem_ready delayed 3 cycles ----
        a_prog[0] = I_LW; a_prog[1] = I_SW; a_prog[2] = I_ADD;
        a_dly = 3;
        start_a();
        run_a(22, 0);
        chk("t2_rd_cycles", rd_n, 4);
        chk("t2_wr_cycles", wr_n, 4);
        exp_q = '{32'd8, 32'd19};
        chk_queue("t2_reg_we", we_q);
        exp_q = '{32'd20};
        chk_queue("t2_done", done_q);
        chk("t2_ret", a_ret, 3);
        chk("t2_cyc", a_cyc, 19);

        // ---- reset during MEM drops requests asynchronously ----
        a_prog[0] = I_ADD; a_prog[1] = I_LW;
        a_dly = 20;
        start_a();
        begin
            int found = 0;
            for (int i = 0; i < 20 && found == 0; i++) begin
                if (a_state == MEM) found = 1;
                else @(negedge clk);
            end
            chk("t5_reach_mem", found, 1);
        end
        @(negedge clk);
        chk("t5_req_before", a_bus.dmem_req, 1);
        chk("t5_pc_before", a_pc, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_req_async", a_bus.dmem_req, 0);
        chk("t5_busy_async", a_busy, 0);
        chk("t5_pc_async", a_pc, 0);
        chk("t5_state_async", a_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        a_dly = 0;
        @(negedge clk);

        // ---- fetch timeout -> sticky ERR ----
        a_imem_en = 1'b0;
        start_a();
        run_a(12, 0);
        chk("t4_fetch_cycles", ireq_n, 8);
        chk("t4_err_cycle", err_at, 9);
        chk("t4_state", a_state, ERR);
        chk("t4_busy", a_busy, 0);
        chk("t4_cyc", a_cyc, 8);
        start_a();
        repeat (2) @(negedge clk);
        chk("t4_start_ignored", a_state, ERR);
        chk("t4_err_sticky", a_err, 1);
        chk("t4_req_low", a_bus.imem_req, 0);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_err", a_err, 0);
        chk("t4_rst_state", a_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        a_imem_en = 1'b1;
        @(negedge clk);

        // ---- branches on instance B ----
        for (int i = 0; i < 5; i++) b_prog[i] = I_ADD;
        b_prog[5] = I_BR; b_prog[6] = I_BR;
        b_br_cond = 1'b1; b_br_target = 8'h02;
        start_b();
        wait_b(EXEC, 8'd5, 60, "t3_br1_exec");
        @(negedge clk);
        chk("t3_taken_state", b_state, FETCH);
        chk("t3_taken_pc", b_pc, 2);
        b_br_cond = 1'b0;
        wait_b(EXEC, 8'd5, 60, "t3_br2_exec");
        @(negedge clk);
        chk("t3_nottaken_state", b_state, FETCH);
        chk("t3_nottaken_pc", b_pc, 6);
        b_br_cond = 1'b1; b_br_target = 8'hFF;
        wait_b(HALT, 8'hFF, 20, "t3_halt");
        chk("t3_done", b_done, 1);
        chk("t3_ret", b_ret, 11);
        chk("t3_cyc_sat", b_cyc, 15);
        @(negedge clk);
        chk("t3_idle", b_state, IDLE);
        chk("t3_done_pulse", b_done, 0);

        // ---- 20-instruction program saturates the 4-bit retire counter ----
        for (int i = 0; i < 19; i++) b_prog[i] = I_ADD;
        b_prog[19] = I_BR;
        start_b();
        chk("t6_clr_ret", b_ret, 0);
        chk("t6_clr_cyc", b_cyc, 0);
        wait_b(HALT, 8'hFF, 200, "t6_halt");
        chk("t6_ret_sat", b_ret, 15);
        chk("t6_cyc_sat", b_cyc, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
